// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit_pkg
//  Description : Shared fetch-stage constants: FSM state codes, Jump
//                encodings, NOP word, reset/exception/interrupt vectors and
//                the sequential next-PC helper.
//  Revision    : 1.0  initial release
// ============================================================================
package if_fetch_unit_pkg;

   // Fetch FSM state codes
   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_DROP = 2'd3;

   // Jump field encodings from ID control (2'b11 behaves as sequential)
   localparam logic [1:0] JUMP_SEQ = 2'b00;
   localparam logic [1:0] JUMP_J   = 2'b01;
   localparam logic [1:0] JUMP_JR  = 2'b10;

   // Vectors and bubble word, shared with control/exception logic
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h8000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0004;
   localparam logic [31:0] DEF_INT_VECTOR   = 32'h8000_0008;
   localparam logic [31:0] DEF_NOP_INSTR    = 32'h0000_0000;

   // Sequential successor: +4 wraps inside the low 31 bits so the
   // kernel/user mode bit PC[31] never flips on straight-line code.
   function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
      return {pc[31], pc[30:0] + 31'd4};
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit_if
//  Description : Bundle of fetch-stage signals: ID redirects, hazard stall,
//                instruction-memory port and IF/ID register outputs.
//                master = fetch unit, slave = surrounding pipeline/memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface if_fetch_unit_if;

   // Hazard unit / ID stage
   logic        Stall;
   logic [1:0]  Jump;
   logic        Branch;
   logic        BranchCond;
   logic [31:0] JumpTarget;
   logic [31:0] JrTarget;
   logic        Exception;
   logic        Interrupt;

   // Instruction memory
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemRdy;
   logic [31:0] IMemData;

   // IF/ID register
   logic [31:0] IFID_Instruction;
   logic [31:0] IFID_PC;
   logic        IFID_Valid;

   modport master (
      input  Stall, Jump, Branch, BranchCond, JumpTarget, JrTarget,
             Exception, Interrupt, IMemRdy, IMemData,
      output IMemReq, IMemAddr, IFID_Instruction, IFID_PC, IFID_Valid
   );

   modport slave (
      output Stall, Jump, Branch, BranchCond, JumpTarget, JrTarget,
             Exception, Interrupt, IMemRdy, IMemData,
      input  IMemReq, IMemAddr, IFID_Instruction, IFID_PC, IFID_Valid
   );

endinterface
`default_nettype wire

// File: rtl/if_fetch_unit_next_pc.sv
`default_nettype none
// ============================================================================
//  Module      : if_next_pc
//  Description : Combinational redirect priority resolver and sequential
//                PC+4 generator for the fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
module if_next_pc
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
   parameter logic [31:0] INT_VECTOR = DEF_INT_VECTOR
) (
   input  logic        stall,
   input  logic        interrupt,
   input  logic        exception,
   input  logic [1:0]  jump,
   input  logic        branch,
   input  logic        branch_cond,
   input  logic [31:2] jump_target,
   input  logic [30:2] jr_target,
   input  logic        ifid_pc_msb,
   input  logic [31:0] cur_pc,
   output logic        redirect,
   output logic [31:0] redirect_target,
   output logic [31:0] pc_seq
);

   assign pc_seq = seq_next_pc(cur_pc);

   // Resolve redirect source by priority; nothing is taken while stalled
   always_comb begin
      redirect        = 1'b0;
      redirect_target = 32'h0000_0000;
      if (!stall) begin
         if (interrupt) begin
            redirect        = 1'b1;
            redirect_target = INT_VECTOR;
         end else if (exception) begin
            redirect        = 1'b1;
            redirect_target = EXC_VECTOR;
         end else if (jump == JUMP_J) begin
            redirect        = 1'b1;
            redirect_target = {jump_target, 2'b00};
         end else if (jump == JUMP_JR) begin
            // jr/jalr cannot change mode: keep the issuing PC's bit 31
            redirect        = 1'b1;
            redirect_target = {ifid_pc_msb, jr_target, 2'b00};
         end else if (branch && branch_cond) begin
            redirect        = 1'b1;
            redirect_target = {jump_target, 2'b00};
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, issues instruction
//                memory reads through a BOOT/REQ/HOLD/DROP FSM, buffers a
//                response that arrives during a stall, squashes wrong-path
//                responses and fills the IF/ID register.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
   parameter logic [31:0] INT_VECTOR   = DEF_INT_VECTOR,
   parameter logic [31:0] NOP_INSTR    = DEF_NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   if_fetch_unit_if.master bus
);

   logic [1:0]  state_q,      state_d;
   logic [31:0] pc_q,         pc_d;
   logic [31:0] target_q,     target_d;
   logic [31:0] skid_q,       skid_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_q,    ifid_pc_d;
   logic        ifid_valid_q, ifid_valid_d;

   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] pc_seq;

   if_next_pc #(
      .EXC_VECTOR (EXC_VECTOR),
      .INT_VECTOR (INT_VECTOR)
   ) u_next_pc (
      .stall           (bus.Stall),
      .interrupt       (bus.Interrupt),
      .exception       (bus.Exception),
      .jump            (bus.Jump),
      .branch          (bus.Branch),
      .branch_cond     (bus.BranchCond),
      .jump_target     (bus.JumpTarget[31:2]),
      .jr_target       (bus.JrTarget[30:2]),
      .ifid_pc_msb     (ifid_pc_q[31]),
      .cur_pc          (pc_q),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .pc_seq          (pc_seq)
   );

   // A request is outstanding in REQ and while draining a squashed one in DROP;
   // the address stays on pc_q until that response arrives.
   assign bus.IMemReq          = (state_q == ST_REQ) || (state_q == ST_DROP);
   assign bus.IMemAddr         = pc_q;
   assign bus.IFID_Instruction = ifid_instr_q;
   assign bus.IFID_PC          = ifid_pc_q;
   assign bus.IFID_Valid       = ifid_valid_q;

   // Fetch FSM, PC update, skid buffer and IF/ID next-state
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      target_d     = target_q;
      skid_d       = skid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;

      // When not stalled IF/ID takes a bubble unless a word is delivered
      // below; this also gives the one-bubble penalty on every redirect.
      if (!bus.Stall) begin
         ifid_instr_d = NOP_INSTR;
         ifid_valid_d = 1'b0;
      end

      case (state_q)
         ST_BOOT: begin
            if (redirect) begin
               pc_d = redirect_target;
            end
            state_d = ST_REQ;
         end

         ST_REQ: begin
            if (redirect) begin
               if (bus.IMemRdy) begin
                  pc_d = redirect_target;
               end else begin
                  target_d = redirect_target;
                  state_d  = ST_DROP;
               end
            end else if (bus.Stall) begin
               if (bus.IMemRdy) begin
                  skid_d  = bus.IMemData;
                  state_d = ST_HOLD;
               end
            end else if (bus.IMemRdy) begin
               ifid_instr_d = bus.IMemData;
               ifid_pc_d    = pc_q;
               ifid_valid_d = 1'b1;
               pc_d         = pc_seq;
            end
         end

         ST_HOLD: begin
            if (redirect) begin
               pc_d    = redirect_target;
               state_d = ST_REQ;
            end else if (!bus.Stall) begin
               ifid_instr_d = skid_q;
               ifid_pc_d    = pc_q;
               ifid_valid_d = 1'b1;
               pc_d         = pc_seq;
               state_d      = ST_REQ;
            end
         end

         ST_DROP: begin
            // Latest redirect wins over an earlier latched one
            if (redirect) begin
               target_d = redirect_target;
            end
            if (bus.IMemRdy) begin
               pc_d    = target_d;
               state_d = ST_REQ;
            end
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_VECTOR;
         target_q     <= RESET_VECTOR;
         skid_q       <= NOP_INSTR;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc_q    <= 32'h0000_0000;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         target_q     <= target_d;
         skid_q       <= skid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Directed self-checking bench for if_fetch_unit. Memory
//                returns addr ^ 32'hA5A5_0000 whenever the bench raises Rdy.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   if_fetch_unit_if bus ();

   if_fetch_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // Memory data follows the presented address
   always_comb bus.IMemData = mem_word(bus.IMemAddr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      bus.Stall      = 1'b0;
      bus.Jump       = 2'b00;
      bus.Branch     = 1'b0;
      bus.BranchCond = 1'b0;
      bus.JumpTarget = 32'h0;
      bus.JrTarget   = 32'h0;
      bus.Exception  = 1'b0;
      bus.Interrupt  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (bus.IMemReq !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.IMemReq); end
      checks++; if (bus.IFID_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.IFID_Valid); end
      checks++; if (bus.IFID_Instruction !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 00000000", bus.IFID_Instruction); end
      checks++; if (bus.IFID_PC !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 00000000", bus.IFID_PC); end
      checks++; if (bus.IMemAddr !== 32'h8000_0000) begin errors++; $display("FAIL rst_addr: got %h want 80000000", bus.IMemAddr); end
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      bus.IMemRdy = 1'b1;
      tick();   // BOOT -> REQ
      checks++; if (bus.IMemReq !== 1'b1) begin errors++; $display("FAIL seq_req: got %b want 1", bus.IMemReq); end
      checks++; if (bus.IMemAddr !== 32'h8000_0000) begin errors++; $display("FAIL seq_addr0: got %h want 80000000", bus.IMemAddr); end
      checks++; if (bus.IFID_Valid !== 1'b0) begin errors++; $display("FAIL seq_valid0: got %b want 0", bus.IFID_Valid); end
      tick();
      checks++; if (bus.IMemAddr !== 32'h8000_0004) begin errors++; $display("FAIL seq_addr1: got %h want 80000004", bus.IMemAddr); end
      checks++; if (bus.IFID_Valid !== 1'b1) begin errors++; $display("FAIL seq_valid1: got %b want 1", bus.IFID_Valid); end
      checks++; if (bus.IFID_PC !== 32'h8000_0000) begin errors++; $display("FAIL seq_pc1: got %h want 80000000", bus.IFID_PC); end
      checks++; if (bus.IFID_Instruction !== mem_word(32'h8000_0000)) begin errors++; $display("FAIL seq_instr1: got %h want %h", bus.IFID_Instruction, mem_word(32'h8000_0000)); end
      tick();
      checks++; if (bus.IMemAddr !== 32'h8000_0008) begin errors++; $display("FAIL seq_addr2: got %h want 80000008", bus.IMemAddr); end
      checks++; if (bus.IFID_PC !== 32'h8000_0004) begin errors++; $display("FAIL seq_pc2: got %h want 80000004", bus.IFID_PC); end
   endtask

   task automatic test_branch();
      bus.IMemRdy = 1'b1;
      bus.Jump = 2'b01; bus.JumpTarget = 32'h0040_0010;
      tick(); clear_ctl();
      checks++; if (bus.IMemAddr !== 32'h0040_0010) begin errors++; $display("FAIL j_addr: got %h want 00400010", bus.IMemAddr); end
      tick();
      checks++; if (bus.IFID_PC !== 32'h0040_0010 || bus.IFID_Valid !== 1'b1) begin errors++; $display("FAIL j_ifid: got pc %h v %b want 00400010 v 1", bus.IFID_PC, bus.IFID_Valid); end
      bus.Branch = 1'b1; bus.BranchCond = 1'b1; bus.JumpTarget = 32'h0040_0040;
      tick(); clear_ctl();
      checks++; if (bus.IFID_Valid !== 1'b0 || bus.IFID_Instruction !== 32'h0) begin errors++; $display("FAIL br_bubble: got instr %h v %b want 00000000 v 0", bus.IFID_Instruction, bus.IFID_Valid); end
      checks++; if (bus.IMemAddr !== 32'h0040_0040) begin errors++; $display("FAIL br_addr: got %h want 00400040", bus.IMemAddr); end
      // Not-taken branch is sequential
      bus.Branch = 1'b1; bus.BranchCond = 1'b0; bus.JumpTarget = 32'h0040_0998;
      tick(); clear_ctl();
      checks++; if (bus.IMemAddr !== 32'h0040_0044) begin errors++; $display("FAIL br_nt_addr: got %h want 00400044", bus.IMemAddr); end
      checks++; if (bus.IFID_PC !== 32'h0040_0040 || bus.IFID_Valid !== 1'b1) begin errors++; $display("FAIL br_nt_ifid: got pc %h v %b want 00400040 v 1", bus.IFID_PC, bus.IFID_Valid); end
   endtask

   task automatic test_stall();
      bus.IMemRdy = 1'b1;
      bus.Jump = 2'b01; bus.JumpTarget = 32'h0040_001C;
      tick(); clear_ctl();
      tick();   // delivers 0x0040001C, now requesting 0x00400020
      checks++; if (bus.IMemAddr !== 32'h0040_0020) begin errors++; $display("FAIL st_pre_addr: got %h want 00400020", bus.IMemAddr); end
      bus.Stall = 1'b1;
      tick();   // response captured into skid
      bus.IMemRdy = 1'b0;
      checks++; if (bus.IMemReq !== 1'b0) begin errors++; $display("FAIL st_hold_req: got %b want 0", bus.IMemReq); end
      checks++; if (bus.IFID_PC !== 32'h0040_001C || bus.IFID_Valid !== 1'b1) begin errors++; $display("FAIL st_hold_ifid: got pc %h v %b want 0040001c v 1", bus.IFID_PC, bus.IFID_Valid); end
      bus.Interrupt = 1'b1;   // ignored under stall
      tick();
      bus.Interrupt = 1'b0;
      checks++; if (bus.IMemReq !== 1'b0 || bus.IFID_Instruction !== mem_word(32'h0040_001C)) begin errors++; $display("FAIL st_hold2: got req %b instr %h want 0 %h", bus.IMemReq, bus.IFID_Instruction, mem_word(32'h0040_001C)); end
      tick();
      checks++; if (bus.IMemAddr !== 32'h0040_0020) begin errors++; $display("FAIL st_hold_addr: got %h want 00400020", bus.IMemAddr); end
      bus.Stall = 1'b0;
      tick();
      checks++; if (bus.IFID_PC !== 32'h0040_0020 || bus.IFID_Valid !== 1'b1) begin errors++; $display("FAIL st_rel_ifid: got pc %h v %b want 00400020 v 1", bus.IFID_PC, bus.IFID_Valid); end
      checks++; if (bus.IFID_Instruction !== mem_word(32'h0040_0020)) begin errors++; $display("FAIL st_rel_instr: got %h want %h", bus.IFID_Instruction, mem_word(32'h0040_0020)); end
      checks++; if (bus.IMemAddr !== 32'h0040_0024 || bus.IMemReq !== 1'b1) begin errors++; $display("FAIL st_rel_addr: got %h req %b want 00400024 req 1", bus.IMemAddr, bus.IMemReq); end
   endtask

   task automatic test_drop();
      bus.IMemRdy = 1'b0;
      bus.Jump = 2'b01; bus.JumpTarget = 32'h0040_0100;
      tick();
      checks++; if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h0040_0024) begin errors++; $display("FAIL dr_enter: got req %b addr %h want 1 00400024", bus.IMemReq, bus.IMemAddr); end
      checks++; if (bus.IFID_Valid !== 1'b0) begin errors++; $display("FAIL dr_bubble: got %b want 0", bus.IFID_Valid); end
      bus.JumpTarget = 32'h0040_0200;   // newer redirect overrides
      tick(); clear_ctl();
      checks++; if (bus.IMemAddr !== 32'h0040_0024) begin errors++; $display("FAIL dr_hold_addr: got %h want 00400024", bus.IMemAddr); end
      bus.IMemRdy = 1'b1;   // stale response arrives on the third cycle
      tick();
      checks++; if (bus.IMemAddr !== 32'h0040_0200) begin errors++; $display("FAIL dr_target: got %h want 00400200", bus.IMemAddr); end
      checks++; if (bus.IFID_Valid !== 1'b0 || bus.IFID_Instruction !== 32'h0) begin errors++; $display("FAIL dr_stale: got instr %h v %b want 00000000 v 0", bus.IFID_Instruction, bus.IFID_Valid); end
      tick();
      checks++; if (bus.IFID_PC !== 32'h0040_0200 || bus.IFID_Instruction !== mem_word(32'h0040_0200)) begin errors++; $display("FAIL dr_after: got pc %h instr %h want 00400200 %h", bus.IFID_PC, bus.IFID_Instruction, mem_word(32'h0040_0200)); end
   endtask

   task automatic test_priority();
      bus.IMemRdy = 1'b1;
      bus.Interrupt = 1'b1; bus.Exception = 1'b1; bus.Jump = 2'b01; bus.JumpTarget = 32'h0040_0300;
      tick(); clear_ctl();
      checks++; if (bus.IMemAddr !== 32'h8000_0008 || bus.IFID_Valid !== 1'b0) begin errors++; $display("FAIL pr_int: got addr %h v %b want 80000008 v 0", bus.IMemAddr, bus.IFID_Valid); end
      bus.Exception = 1'b1; bus.Jump = 2'b01; bus.JumpTarget = 32'h0040_0300; bus.Branch = 1'b1; bus.BranchCond = 1'b1;
      tick(); clear_ctl();
      checks++; if (bus.IMemAddr !== 32'h8000_0004) begin errors++; $display("FAIL pr_exc: got %h want 80000004", bus.IMemAddr); end
      tick();
      checks++; if (bus.IFID_PC !== 32'h8000_0004 || bus.IFID_Valid !== 1'b1) begin errors++; $display("FAIL pr_exc_ifid: got pc %h v %b want 80000004 v 1", bus.IFID_PC, bus.IFID_Valid); end
      bus.Jump = 2'b10; bus.JrTarget = 32'h0000_1230; bus.JumpTarget = 32'h0040_0300;
      tick(); clear_ctl();
      checks++; if (bus.IMemAddr !== 32'h8000_1230) begin errors++; $display("FAIL pr_jr: got %h want 80001230", bus.IMemAddr); end
      bus.Jump = 2'b11; bus.JumpTarget = 32'h0040_0300;
      tick(); clear_ctl();
      checks++; if (bus.IMemAddr !== 32'h8000_1234 || bus.IFID_PC !== 32'h8000_1230) begin errors++; $display("FAIL pr_j11: got addr %h pc %h want 80001234 80001230", bus.IMemAddr, bus.IFID_PC); end
      bus.IMemRdy = 1'b0; bus.Stall = 1'b1; bus.Interrupt = 1'b1;
      tick(); clear_ctl();
      checks++; if (bus.IMemAddr !== 32'h8000_1234 || bus.IFID_Valid !== 1'b1 || bus.IFID_PC !== 32'h8000_1230) begin errors++; $display("FAIL pr_stall_int: got addr %h v %b pc %h want 80001234 1 80001230", bus.IMemAddr, bus.IFID_Valid, bus.IFID_PC); end
   endtask

   task automatic test_pc_wrap();
      bus.IMemRdy = 1'b1;
      bus.Jump = 2'b01; bus.JumpTarget = 32'h7FFF_FFFC;
      tick(); clear_ctl();
      tick();
      checks++; if (bus.IMemAddr !== 32'h0000_0000) begin errors++; $display("FAIL wr_user: got %h want 00000000", bus.IMemAddr); end
      bus.Jump = 2'b10; bus.JrTarget = 32'h8000_0ABC;   // bit 31 comes from IFID_PC (0)
      tick(); clear_ctl();
      checks++; if (bus.IMemAddr !== 32'h0000_0ABC) begin errors++; $display("FAIL wr_jr_user: got %h want 00000abc", bus.IMemAddr); end
      bus.Jump = 2'b01; bus.JumpTarget = 32'hFFFF_FFFC;
      tick(); clear_ctl();
      tick();
      checks++; if (bus.IMemAddr !== 32'h8000_0000) begin errors++; $display("FAIL wr_kernel: got %h want 80000000", bus.IMemAddr); end
   endtask

   task automatic test_reset_in_drop();
      bus.IMemRdy = 1'b1;
      tick();   // now requesting 0x80000004
      bus.IMemRdy = 1'b0;
      bus.Jump = 2'b01; bus.JumpTarget = 32'h0040_0500;
      tick(); clear_ctl();
      checks++; if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h8000_0004) begin errors++; $display("FAIL rd_drop: got req %b addr %h want 1 80000004", bus.IMemReq, bus.IMemAddr); end
      reset = 1'b1; bus.IMemRdy = 1'b1;
      tick();
      checks++; if (bus.IMemReq !== 1'b0 || bus.IMemAddr !== 32'h8000_0000) begin errors++; $display("FAIL rd_rst_mem: got req %b addr %h want 0 80000000", bus.IMemReq, bus.IMemAddr); end
      checks++; if (bus.IFID_Valid !== 1'b0 || bus.IFID_PC !== 32'h0 || bus.IFID_Instruction !== 32'h0) begin errors++; $display("FAIL rd_rst_ifid: got v %b pc %h instr %h want 0 00000000 00000000", bus.IFID_Valid, bus.IFID_PC, bus.IFID_Instruction); end
      reset = 1'b0;
      tick();
      checks++; if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h8000_0000 || bus.IFID_Valid !== 1'b0) begin errors++; $display("FAIL rd_boot: got req %b addr %h v %b want 1 80000000 0", bus.IMemReq, bus.IMemAddr, bus.IFID_Valid); end
      tick();
      checks++; if (bus.IFID_PC !== 32'h8000_0000 || bus.IFID_Instruction !== mem_word(32'h8000_0000)) begin errors++; $display("FAIL rd_first: got pc %h instr %h want 80000000 %h", bus.IFID_PC, bus.IFID_Instruction, mem_word(32'h8000_0000)); end
   endtask

   initial begin
      reset       = 1'b1;
      bus.IMemRdy = 1'b0;
      clear_ctl();
      test_reset();
      test_sequential();
      test_branch();
      test_stall();
      test_drop();
      test_priority();
      test_pc_wrap();
      test_reset_in_drop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
